ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit beside the EX-stage ALU: MULT/MULTU/DIV/DIVU into HI/LO,
//   MTHI/MTLO writes, MFHI/MFLO reads. Width-parametrised. Runs one radix-2 step per cycle
//   and raises a stall to the hazard unit only when a dependent MD instruction arrives.
//   A flush cancels an in-flight operation.
// PARAMETERS
//   WIDTH      32  operand, HI and LO width (even, >=8)
//   SIGNED_EN  1   0: MULT/DIV execute as MULTU/DIVU
// PORTS
//   clk       in   1      clock, rising edge
//   rst_n     in   1      asynchronous reset, active low
//   start     in   1      EX holds an MD op this cycle (valid, not stalled)
//   op        in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others NOP
//   a         in   WIDTH  rs value (already forwarded); dividend / multiplicand / MT data
//   b         in   WIDTH  rt value (already forwarded); divisor / multiplier
//   mf_req    in   1      EX holds MFHI/MFLO this cycle
//   mf_sel    in   1      0 = LO, 1 = HI
//   flush     in   1      interrupt/exception flush of EX
//   mf_data   out  WIDTH  selected HI/LO, combinational from registers
//   stall_o   out  1      hold IF..EX this cycle
//   busy      out  1      state==RUN
//   done      out  1      one-cycle completion pulse
//   hi, lo    out  WIDTH  architectural HI/LO
// BEHAVIOUR
//   Reset: state=IDLE; hi=lo=0; busy=done=stall_o=0; iteration count=0.
//   States: IDLE, RUN, DONE.
//   IDLE:
//     - start & op in {MULT..DIVU} & !flush -> latch |a|,|b| and result signs, cnt=0, -> RUN.
//     - start & MTHI / MTLO & !flush -> hi / lo = a at this edge; stay IDLE.
//   RUN:
//     - Each cycle does one shift-add (mul) or restoring-subtract (div) step; cnt++.
//     - At the edge where cnt reaches WIDTH-1, sign-corrected hi/lo are written, -> DONE.
//   DONE: done=1 for one cycle; behaves as IDLE for start/mf_req acceptance; -> IDLE
//     (or RUN if a new op is accepted).
//   Latency: start sampled at cycle T; RUN is T+1..T+WIDTH; done=1 and new hi/lo are
//     visible at T+WIDTH+1.
//   Results:
//     - mul: {hi,lo} = full 2*WIDTH-bit product.
//     - div: lo = quotient, hi = remainder. Truncate toward zero; remainder takes the
//       dividend's sign.
//     - b==0 on DIV/DIVU: lo = all ones, hi = a. No trap; full latency.
//     - DIV MIN/-1: lo = MIN, hi = 0.
//   stall_o = busy & (start | mf_req). An op presented while busy is not accepted; it is
//     re-presented after the stall. stall_o never depends on flush.
//   mf_data = mf_sel ? hi : lo. It is only meaningful when stall_o=0.
//   flush:
//     - In RUN: -> IDLE next edge; hi/lo unchanged; no done pulse.
//     - In IDLE/DONE with start: the op is ignored (flush wins).
//   Reset asserted mid-RUN: immediate return to reset values.
// TESTING
//   MULT a=FFFFFFFD(-3), b=5 -> at T+33 done=1, hi=FFFFFFFF, lo=FFFFFFF1; busy high T+1..T+32.
//   DIV a=FFFFFFF9(-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU same operands -> lo=7FFFFFFC, hi=1.
//   DIVU a=1234, b=0 -> lo=FFFFFFFF, hi=00001234; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//   MULTU started, MFHI at T+5 -> stall_o=1 through T+32; at T+33 mf_data=product hi, stall_o=0.
//   flush at T+10 of a DIV -> IDLE at T+11, hi/lo keep prior values, done never pulses.
//   MTLO a=CAFEF00D in IDLE -> lo=CAFEF00D next cycle; rst_n low mid-RUN -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Bundle between the EX stage and the iterative multiply/divide unit.
//   start/op/a/b/flush : operation issue (MULT/MULTU/DIV/DIVU/MTHI/MTLO) and cancel
//   mf_req/mf_sel      : MFHI/MFLO read request and HI/LO select
//   mf_data            : selected HI/LO value
//   stall_o/busy/done  : hazard stall, RUN indication, one-cycle completion pulse
//   hi/lo              : architectural HI/LO
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic             mf_sel;
    logic             flush;
    logic [WIDTH-1:0] mf_data;
    logic             stall_o;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mf_req, mf_sel, flush,
        input  mf_data, stall_o, busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mf_req, mf_sel, flush,
        output mf_data, stall_o, busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   md         : slave side of ex_muldiv_if (issue, MF read, stall/busy/done, HI/LO)
// Operands are converted to magnitudes on accept; one shift-add (mul) or restoring
// subtract (div) step per RUN cycle; sign correction is applied when HI/LO are written.
module ex_muldiv_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          SIGNED_EN = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    ex_muldiv_if.slave  md
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   work_q, work_d;   // mul: {acc, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;     // product / quotient sign
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                 op_signed, a_neg, b_neg, is_md_op;
    logic [WIDTH-1:0]     a_mag, b_mag, quot, rem;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   step, prod;

    always_comb begin
        is_md_op  = ~md.op[2];
        op_signed = SIGNED_EN && !md.op[0];
        a_neg     = op_signed & md.a[WIDTH-1];
        b_neg     = op_signed & md.b[WIDTH-1];
        a_mag     = a_neg ? -md.a : md.a;
        b_mag     = b_neg ? -md.b : md.b;

        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opnd_q : '0)};
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        // Bit WIDTH of the difference is set exactly when the shifted remainder < divisor.
        div_diff  = div_shift - {1'b0, opnd_q};

        if (is_div_q) begin
            if (!div_diff[WIDTH]) step = {div_diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
            else                  step = {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        end else begin
            step = {mul_sum, work_q[WIDTH-1:1]};
        end

        prod = neg_q ? -step : step;
        quot = step[WIDTH-1:0];
        rem  = step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (md.start && !md.flush) begin
                    if (is_md_op) begin
                        state_d    = StRun;
                        cnt_d      = '0;
                        is_div_d   = md.op[1];
                        neg_d      = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        div_zero_d = (md.b == '0);
                        opnd_d     = md.op[1] ? b_mag : a_mag;
                        work_d     = md.op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    end else if (md.op == 3'b100) begin
                        hi_d = md.a;
                    end else if (md.op == 3'b101) begin
                        lo_d = md.a;
                    end
                end
            end
            StRun: begin
                if (md.flush) begin
                    state_d = StIdle;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                        if (is_div_q) begin
                            // Divide by zero: all-ones quotient, remainder equals the dividend.
                            lo_d = div_zero_q ? '1 : (neg_q ? -quot : quot);
                            hi_d = neg_rem_q ? -rem : rem;
                        end else begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign md.busy    = (state_q == StRun);
    assign md.done    = (state_q == StDone);
    assign md.stall_o = md.busy & (md.start | md.mf_req);
    assign md.mf_data = md.mf_sel ? hi_q : lo_q;
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;
endmodule
